// File: rtl/arb2_rr_pkg.sv
// Shared constants for the two-input round-robin arbiter.
// Source encoding matches the select polarity of the downstream 2:1 mux.
package arb2_rr_pkg;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant logic with its priority flop.
// Ready is grant qualified by the output stage's ability to load.
module rr_grant2
  import arb2_rr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic load_ok,
  output logic a_ready,
  output logic b_ready
);

  logic prio;
  logic grant_a;
  logic grant_b;

  always_comb begin
    grant_a = a_valid && (!b_valid || (prio == SRC_A));
    grant_b = b_valid && (!a_valid || (prio == SRC_B));
  end

  assign a_ready = grant_a && load_ok;
  assign b_ready = grant_b && load_ok;

  // Priority moves to the loser only when a grant is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= SRC_A;
    end else if (a_ready) begin
      prio <= SRC_B;
    end else if (b_ready) begin
      prio <= SRC_A;
    end
  end

endmodule

// File: rtl/arb2_rr.sv
// Round-robin arbiter between two valid/ready sources feeding a
// one-entry output register, with per-source accepted-beat counters.
module arb2_rr
  import arb2_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic load_ok;

  assign load_ok = !out_valid || out_ready;

  rr_grant2 u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .load_ok (load_ok),
    .a_ready (a_ready),
    .b_ready (b_ready)
  );

  // A handshake without a new accept empties the stage but keeps the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_B;
    end else if (a_ready) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_src   <= SRC_A;
    end else if (b_ready) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_src   <= SRC_B;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready) cnt_a <= cnt_a + CNT_W'(1);
      if (b_ready) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

endmodule
